// File: rtl/serial_subtractor_if.sv
// ============================================================================
// Module      : serial_subtractor_if
// Description : Operand/result bundle for serial_subtractor. Optional zero/ovf
//               flags exist only when SERIAL_SUB_FLAGS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
`ifdef SERIAL_SUB_FLAGS_EN
   logic             zero;
   logic             ovf;

   modport master (output start, a, b, input busy, done, diff, borrow, zero, ovf);
   modport slave  (input start, a, b, output busy, done, diff, borrow, zero, ovf);
`else
   modport master (output start, a, b, input busy, done, diff, borrow);
   modport slave  (input start, a, b, output busy, done, diff, borrow);
`endif
endinterface

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial a - b, LSB first, one full-adder cell with b
//               inverted and carry-in 1. Optional flags: SERIAL_SUB_FLAGS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  wire logic            clk,
   input  wire logic            rst,
   serial_subtractor_if.slave   bus
);

   localparam int              CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             w_busy;
   logic             w_last;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_diff;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic             r_borrow;
   logic             r_done;
   logic             w_sum;
   logic             w_cout;
   logic [WIDTH-1:0] w_res_nxt;

   assign w_sum     = r_sa[0] ^ r_sb[0] ^ r_carry;
   assign w_cout    = (r_sa[0] & r_sb[0]) | (r_sa[0] & r_carry) | (r_sb[0] & r_carry);
   assign w_res_nxt = {w_sum, r_res[WIDTH-1:1]};
   assign w_last    = (r_cnt == LAST_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_busy      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_busy = 1'b1;
            if (w_last) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sa     <= '0;
         r_sb     <= '0;
         r_res    <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_diff   <= '0;
         r_borrow <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_sa    <= bus.a;
                  r_sb    <= ~bus.b;
                  r_carry <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            RUN: begin
               r_carry <= w_cout;
               r_res   <= w_res_nxt;
               r_sa    <= r_sa >> 1;
               r_sb    <= r_sb >> 1;
               r_cnt   <= r_cnt + 1'b1;
               if (w_last) begin
                  r_diff   <= w_res_nxt;
                  r_borrow <= ~w_cout;
                  r_done   <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SERIAL_SUB_FLAGS_EN
   logic r_zero;
   logic r_ovf;

   // On the last bit r_carry is the carry into the MSB and w_cout the carry out.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_zero <= 1'b0;
         r_ovf  <= 1'b0;
      end else if ((r_state == RUN) && w_last) begin
         r_zero <= (w_res_nxt == '0);
         r_ovf  <= r_carry ^ w_cout;
      end
   end

   assign bus.zero = r_zero;
   assign bus.ovf  = r_ovf;
`endif

   assign bus.busy   = w_busy;
   assign bus.done   = r_done;
   assign bus.diff   = r_diff;
   assign bus.borrow = r_borrow;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Scoreboard bench for serial_subtractor (SERIAL_SUB_FLAGS_EN
//               adds zero/ovf checks).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] d;
      logic         br;
      logic         z;
      logic         o;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   serial_subtractor_if #(.WIDTH(W)) intf ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (intf.slave)
   );

   always #5 clk = ~clk;

   int   vectors    = 0;
   int   miscompares = 0;
   exp_t sb_q[$];

   // Reference: operation latency as a countdown, results from plain arithmetic.
   int   rem       = 0;
   bit   exp_done  = 1'b0;
   bit   rst_applied = 1'b0;

   function automatic exp_t ref_sub(input logic [W-1:0] av, input logic [W-1:0] bv);
      exp_t   e;
      longint sa;
      longint sbv;
      longint r;
      sa   = $signed(av);
      sbv  = $signed(bv);
      r    = sa - sbv;
      e.d  = av - bv;
      e.br = (av < bv);
      e.z  = (e.d == '0);
      e.o  = (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
      return e;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         rem         = 0;
         exp_done    = 1'b0;
         rst_applied = 1'b1;
         sb_q.delete();
      end else begin
         rst_applied = 1'b0;
         exp_done    = 1'b0;
         if (rem > 0) begin
            rem = rem - 1;
            if (rem == 0) exp_done = 1'b1;
         end else if (intf.start) begin
            rem = W;
            sb_q.push_back(ref_sub(intf.a, intf.b));
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   exp_t held = '{d: '0, br: 1'b0, z: 1'b0, o: 1'b0};

   always @(negedge clk) begin
      if (rst_applied) held = '{d: '0, br: 1'b0, z: 1'b0, o: 1'b0};
      chk("busy", 64'(intf.busy), 64'(rem > 0));
      chk("done", 64'(intf.done), 64'(exp_done));
      if (intf.done) begin
         if (sb_q.size() == 0) chk("unexpected_done", 64'(1), 64'(0));
         else held = sb_q.pop_front();
      end
      chk("diff", 64'(intf.diff), 64'(held.d));
      chk("borrow", 64'(intf.borrow), 64'(held.br));
`ifdef SERIAL_SUB_FLAGS_EN
      chk("zero", 64'(intf.zero), 64'(held.z));
      chk("ovf", 64'(intf.ovf), 64'(held.o));
`endif
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Waits for the model to be idle, so consecutive calls land in the done cycle.
   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input bit junk);
      int guard = 0;
      while (rem != 0 && guard < 100) begin
         tick();
         guard++;
      end
      intf.a     = av;
      intf.b     = bv;
      intf.start = 1'b1;
      tick();
      intf.start = 1'b0;
      if (junk) begin
         for (int i = 0; i < W - 1; i++) begin
            intf.start = 1'($urandom_range(0, 1));
            intf.a     = W'($urandom);
            intf.b     = W'($urandom);
            tick();
         end
      end
      intf.start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      intf.start = 1'b0;
      intf.a     = '0;
      intf.b     = '0;
      rst        = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(20);

      issue(8'd200, 8'd55, 1'b0);
      idle(W + 2);

      issue(8'd5, 8'd7, 1'b0);
      issue(8'd0, 8'd0, 1'b0);
      issue(8'hFF, 8'h00, 1'b0);
      idle(W + 2);

      // start and operand changes during RUN must not disturb the operation
      issue(8'd9, 8'd3, 1'b0);
      idle(2);
      intf.start = 1'b1;
      intf.a     = 8'd1;
      intf.b     = 8'd1;
      tick();
      intf.start = 1'b0;
      intf.a     = 8'd77;
      intf.b     = 8'd200;
      issue(8'd10, 8'd4, 1'b0);
      idle(W + 2);

      issue(8'd100, 8'd1, 1'b0);
      idle(3);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      issue(8'd3, 8'd1, 1'b0);
      idle(W + 2);

      issue(8'h80, 8'h01, 1'b0);
      issue(8'h50, 8'h50, 1'b0);
      issue(8'h7F, 8'hFF, 1'b0);
      idle(W + 2);

      repeat (40) begin
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      end
      idle(W + 3);
      chk("queue_empty", 64'(sb_q.size()), 64'(0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
